hpdmc_wbarb: RTL and testbench

HPDMC_WBARB -- requirements
Module: hpdmc_wbarb

---
 rtl/hpdmc_pkg.sv | 20 ++
 rtl/hpdmc_rrpick.sv | 39 +++
 rtl/hpdmc_wbarb.sv | 158 +++++++++++++++
 tb/tb_hpdmc_wbarb.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hpdmc_pkg.sv
// hpdmc_pkg: shared definitions for the HPDMC WISHBONE front end.
//   - arb_state_e : arbiter FSM encoding (IDLE=0, OWNED=1)
//   - CTI_*       : WISHBONE cycle-type identifiers
//   - wrap_inc    : index increment modulo a master count
package hpdmc_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/hpdmc_rrpick.sv
// hpdmc_rrpick: combinational round-robin picker.
// Ports:
//   req_i   - request vector, one bit per master
//   rr_i    - index with highest priority this round
//   grant_o - one-hot selection (all zero when no request)
//   idx_o   - binary index of the selected master
//   valid_o - at least one request present
module hpdmc_rrpick
  import hpdmc_pkg::*;
#(
  parameter int NM = 3,
  parameter int IW = (NM > 1) ? $clog2(NM) : 1
) (
  input  logic [NM-1:0] req_i,
  input  logic [IW-1:0] rr_i,
  output logic [NM-1:0] grant_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  // Walk the masters starting at rr_i, wrapping at NM; the first hit wins.
  always_comb begin
    int k;
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    k       = 0;
    for (int i = 0; i < NM; i++) begin
      k = int'(rr_i) + i;
      if (k >= NM) k = k - NM;
      if (!valid_o && req_i[k]) begin
        valid_o    = 1'b1;
        idx_o      = IW'(k);
        grant_o[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hpdmc_wbarb.sv
// hpdmc_wbarb: round-robin WISHBONE arbiter in front of the HPDMC memory port.
// A granted master keeps the port for as long as it holds cyc, so bursts are
// never split; after it releases cyc the arbiter spends one idle cycle before
// the next grant.
// Ports:
//   sys_clk, sys_rst       - clock, asynchronous active-high reset
//   m_*_i / m_*_o          - per-master WISHBONE slave side (packed, master k
//                            at slice k of each vector)
//   m_nextadr_*_i          - per-master read-address prediction
//   s_*_o / s_*_i          - muxed WISHBONE master side to the controller
//   s_nextadr_*_o          - muxed prediction
//   grant_o                - one-hot current owner, zero when idle
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no owner; s_* forced low; pick next owner from requests
// OWNED | owner's m_* routed to s_*; ack routed back to owner only
module hpdmc_wbarb
  import hpdmc_pkg::*;
#(
  parameter int nmasters = 3
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,

  input  logic [32*nmasters-1:0] m_adr_i,
  input  logic [3*nmasters-1:0]  m_cti_i,
  input  logic [64*nmasters-1:0] m_dat_i,
  input  logic [8*nmasters-1:0]  m_sel_i,
  input  logic [nmasters-1:0]    m_cyc_i,
  input  logic [nmasters-1:0]    m_stb_i,
  input  logic [nmasters-1:0]    m_we_i,
  output logic [63:0]            m_dat_o,
  output logic [nmasters-1:0]    m_ack_o,
  input  logic [nmasters-1:0]    m_nextadr_valid_i,
  input  logic [32*nmasters-1:0] m_nextadr_i,

  output logic [31:0]            s_adr_o,
  output logic [2:0]             s_cti_o,
  output logic [63:0]            s_dat_o,
  output logic [7:0]             s_sel_o,
  output logic                   s_cyc_o,
  output logic                   s_stb_o,
  output logic                   s_we_o,
  input  logic [63:0]            s_dat_i,
  input  logic                   s_ack_i,
  output logic                   s_nextadr_valid_o,
  output logic [31:0]            s_nextadr_o,

  output logic [nmasters-1:0]    grant_o
);

  localparam int IW = (nmasters > 1) ? $clog2(nmasters) : 1;

  arb_state_e          state_q, state_d;
  logic [IW-1:0]       owner_q, owner_d;
  logic [IW-1:0]       rr_q, rr_d;
  logic [nmasters-1:0] grant_q, grant_d;

  logic [nmasters-1:0] req;
  logic [nmasters-1:0] pick_grant;
  logic [IW-1:0]       pick_idx;
  logic                pick_valid;
  logic                owner_cyc;

  assign req = m_cyc_i & m_stb_i;

  hpdmc_rrpick #(
    .NM (nmasters),
    .IW (IW)
  ) u_rrpick (
    .req_i   (req),
    .rr_i    (rr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
    end
  end

  // grant_q is one-hot of owner_q while OWNED and zero otherwise, so it can
  // select the owner's cyc directly.
  assign owner_cyc = |(grant_q & m_cyc_i);

  // Picking happens only in IDLE, so the cycle that follows a release never
  // routes a new master: that provides the turnaround gap.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = OWNED;
          owner_d = pick_idx;
          grant_d = pick_grant;
        end
      end
      OWNED: begin
        if (!owner_cyc) begin
          state_d = IDLE;
          grant_d = '0;
          rr_d    = IW'(wrap_inc(int'(owner_q), nmasters));
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_comb begin
    s_adr_o           = '0;
    s_cti_o           = '0;
    s_dat_o           = '0;
    s_sel_o           = '0;
    s_cyc_o           = 1'b0;
    s_stb_o           = 1'b0;
    s_we_o            = 1'b0;
    s_nextadr_valid_o = 1'b0;
    s_nextadr_o       = '0;
    m_ack_o           = '0;
    if (state_q == OWNED) begin
      for (int k = 0; k < nmasters; k++) begin
        if (grant_q[k]) begin
          s_adr_o           = m_adr_i[32*k +: 32];
          s_cti_o           = m_cti_i[3*k +: 3];
          s_dat_o           = m_dat_i[64*k +: 64];
          s_sel_o           = m_sel_i[8*k +: 8];
          s_cyc_o           = m_cyc_i[k];
          s_stb_o           = m_stb_i[k];
          s_we_o            = m_we_i[k];
          s_nextadr_valid_o = m_nextadr_valid_i[k];
          s_nextadr_o       = m_nextadr_i[32*k +: 32];
          m_ack_o[k]        = s_ack_i;
        end
      end
    end
  end

  assign m_dat_o = s_dat_i;
  assign grant_o = (state_q == OWNED) ? grant_q : '0;

endmodule

// File: tb/tb_hpdmc_wbarb.sv
// tb_hpdmc_wbarb: directed scenarios plus a randomized run of three WISHBONE
// masters, all checked every cycle against an integer ownership model.
module tb_hpdmc_wbarb;
  import hpdmc_pkg::*;

  localparam int NM = 3;

  logic              sys_clk;
  logic              sys_rst;
  logic [32*NM-1:0]  m_adr_i;
  logic [3*NM-1:0]   m_cti_i;
  logic [64*NM-1:0]  m_dat_i;
  logic [8*NM-1:0]   m_sel_i;
  logic [NM-1:0]     m_cyc_i, m_stb_i, m_we_i;
  logic [63:0]       m_dat_o;
  logic [NM-1:0]     m_ack_o;
  logic [NM-1:0]     m_nextadr_valid_i;
  logic [32*NM-1:0]  m_nextadr_i;
  logic [31:0]       s_adr_o;
  logic [2:0]        s_cti_o;
  logic [63:0]       s_dat_o;
  logic [7:0]        s_sel_o;
  logic              s_cyc_o, s_stb_o, s_we_o;
  logic [63:0]       s_dat_i;
  logic              s_ack_i;
  logic              s_nextadr_valid_o;
  logic [31:0]       s_nextadr_o;
  logic [NM-1:0]     grant_o;

  hpdmc_wbarb #(.nmasters(NM)) dut (
    .sys_clk           (sys_clk),
    .sys_rst           (sys_rst),
    .m_adr_i           (m_adr_i),
    .m_cti_i           (m_cti_i),
    .m_dat_i           (m_dat_i),
    .m_sel_i           (m_sel_i),
    .m_cyc_i           (m_cyc_i),
    .m_stb_i           (m_stb_i),
    .m_we_i            (m_we_i),
    .m_dat_o           (m_dat_o),
    .m_ack_o           (m_ack_o),
    .m_nextadr_valid_i (m_nextadr_valid_i),
    .m_nextadr_i       (m_nextadr_i),
    .s_adr_o           (s_adr_o),
    .s_cti_o           (s_cti_o),
    .s_dat_o           (s_dat_o),
    .s_sel_o           (s_sel_o),
    .s_cyc_o           (s_cyc_o),
    .s_stb_o           (s_stb_o),
    .s_we_o            (s_we_o),
    .s_dat_i           (s_dat_i),
    .s_ack_i           (s_ack_i),
    .s_nextadr_valid_o (s_nextadr_valid_o),
    .s_nextadr_o       (s_nextadr_o),
    .grant_o           (grant_o)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h required %0h", tag, act, exp);
    end
  endtask

  // Reference model: who owns the port (-1 = nobody) and whose turn is next.
  int mdl_owner = -1;
  int mdl_rr    = 0;

  // Master programs and bookkeeping of what the DUT did.
  int            beats [NM];
  bit            auto_rs [NM];
  bit            rnd_mode;
  logic [NM-1:0] ack_seen;
  int            grant_log[$];
  int            gap_log[$];
  int            gap_cnt;
  logic [NM-1:0] prev_grant;
  int            ack_cnt [NM];

  function automatic int log_at(input int i);
    return (i < grant_log.size()) ? grant_log[i] : -1;
  endfunction

  function automatic int gap_at(input int i);
    return (i < gap_log.size()) ? gap_log[i] : -1;
  endfunction

  task automatic clear_log();
    grant_log.delete();
    gap_log.delete();
    gap_cnt    = 0;
    prev_grant = '0;
    for (int k = 0; k < NM; k++) ack_cnt[k] = 0;
  endtask

  task automatic check_outputs();
    logic [NM-1:0] eg, ea;
    logic          ec, es, ew, env;
    logic [31:0]   eadr, ena;
    logic [2:0]    ecti;
    logic [63:0]   edat;
    logic [7:0]    esel;
    eg = '0; ea = '0; ec = 1'b0; es = 1'b0; ew = 1'b0; env = 1'b0;
    eadr = '0; ena = '0; ecti = '0; edat = '0; esel = '0;
    if (mdl_owner >= 0) begin
      int o;
      o    = mdl_owner;
      eg[o] = 1'b1;
      ec   = m_cyc_i[o];
      es   = m_stb_i[o];
      ew   = m_we_i[o];
      env  = m_nextadr_valid_i[o];
      eadr = m_adr_i[32*o +: 32];
      ena  = m_nextadr_i[32*o +: 32];
      ecti = m_cti_i[3*o +: 3];
      edat = m_dat_i[64*o +: 64];
      esel = m_sel_i[8*o +: 8];
      if (s_ack_i) ea[o] = 1'b1;
    end
    chk("grant",   64'(grant_o),           64'(eg));
    chk("s_cyc",   64'(s_cyc_o),           64'(ec));
    chk("s_stb",   64'(s_stb_o),           64'(es));
    chk("s_we",    64'(s_we_o),            64'(ew));
    chk("s_nav",   64'(s_nextadr_valid_o), 64'(env));
    chk("s_adr",   64'(s_adr_o),           64'(eadr));
    chk("s_na",    64'(s_nextadr_o),       64'(ena));
    chk("s_cti",   64'(s_cti_o),           64'(ecti));
    chk("s_dat",   s_dat_o,                edat);
    chk("s_sel",   64'(s_sel_o),           64'(esel));
    chk("m_ack",   64'(m_ack_o),           64'(ea));
    chk("m_dat",   m_dat_o,                s_dat_i);
    ack_seen = ea;
    for (int k = 0; k < NM; k++) if (m_ack_o[k]) ack_cnt[k]++;
    if (grant_o == '0) gap_cnt++;
    else if (grant_o != prev_grant) begin
      for (int k = 0; k < NM; k++) if (grant_o[k]) grant_log.push_back(k);
      gap_log.push_back(gap_cnt);
      gap_cnt = 0;
    end
    prev_grant = grant_o;
  endtask

  task automatic model_edge();
    if (!sys_rst) begin
      if (mdl_owner >= 0) begin
        if (!m_cyc_i[mdl_owner]) begin
          mdl_rr    = (mdl_owner + 1) % NM;
          mdl_owner = -1;
        end
      end else begin
        for (int i = 0; i < NM; i++) begin
          int k;
          k = (mdl_rr + i) % NM;
          if (mdl_owner < 0 && m_cyc_i[k] && m_stb_i[k]) mdl_owner = k;
        end
      end
    end
  endtask

  // Ends one posedge + 1 time unit later, where stimulus is driven.
  task automatic step();
    @(negedge sys_clk);
    check_outputs();
    @(posedge sys_clk);
    model_edge();
    #1;
  endtask

  task automatic start_txn(input int k, input int nb, input logic we, input logic [31:0] adr);
    beats[k]                   = nb;
    m_cyc_i[k]                 = 1'b1;
    m_stb_i[k]                 = 1'b1;
    m_we_i[k]                  = we;
    m_adr_i[32*k +: 32]        = adr;
    m_cti_i[3*k +: 3]          = (nb == 1) ? CTI_CLASSIC : CTI_INCR;
    m_sel_i[8*k +: 8]          = 8'hFF;
    m_dat_i[64*k +: 64]        = {$urandom, $urandom};
    m_nextadr_valid_i[k]       = ~we;
    m_nextadr_i[32*k +: 32]    = adr + 32'd8;
  endtask

  task automatic drop(input int k);
    beats[k]             = 0;
    m_cyc_i[k]           = 1'b0;
    m_stb_i[k]           = 1'b0;
    m_we_i[k]            = 1'b0;
    m_nextadr_valid_i[k] = 1'b0;
  endtask

  task automatic advance();
    for (int k = 0; k < NM; k++) begin
      if (beats[k] > 0) begin
        if (ack_seen[k]) begin
          beats[k]--;
          if (beats[k] == 0) drop(k);
          else begin
            m_adr_i[32*k +: 32] = m_adr_i[32*k +: 32] + 32'd8;
            m_cti_i[3*k +: 3]   = (beats[k] == 1) ? CTI_EOB : CTI_INCR;
            m_dat_i[64*k +: 64] = {$urandom, $urandom};
          end
        end else if (rnd_mode && mdl_owner != k && $urandom_range(15) == 0) begin
          drop(k);
        end
        if (rnd_mode && beats[k] > 0) begin
          m_stb_i[k]              = ($urandom_range(3) != 0);
          m_sel_i[8*k +: 8]       = 8'($urandom);
          m_nextadr_i[32*k +: 32] = $urandom;
        end
      end else if (auto_rs[k] && !m_cyc_i[k]) begin
        start_txn(k, 1, 1'b0, 32'h1000 + 32'(k) * 32'h100);
      end else if (rnd_mode && $urandom_range(3) == 0) begin
        start_txn(k, $urandom_range(1, 4), 1'($urandom_range(1)), $urandom);
      end
    end
  endtask

  task automatic drive_slave();
    s_dat_i = {$urandom, $urandom};
    if (rnd_mode) s_ack_i = 1'($urandom_range(1));
    else if (mdl_owner >= 0) s_ack_i = m_stb_i[mdl_owner];
    else s_ack_i = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      step();
      advance();
      drive_slave();
    end
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    m_adr_i = '0; m_cti_i = '0; m_dat_i = '0; m_sel_i = '0;
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
    m_nextadr_valid_i = '0; m_nextadr_i = '0;
    s_dat_i = '0; s_ack_i = 1'b0;
    rnd_mode = 1'b0;
    for (int k = 0; k < NM; k++) begin
      beats[k]   = 0;
      auto_rs[k] = 1'b0;
    end
    mdl_owner = -1;
    mdl_rr    = 0;
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    clear_log();
  endtask

  initial begin
    // Reset state, with every master requesting and a stray slave ack.
    sys_rst = 1'b1;
    m_adr_i = '1; m_cti_i = '0; m_dat_i = '0; m_sel_i = '1;
    m_cyc_i = '1; m_stb_i = '1; m_we_i = '1;
    m_nextadr_valid_i = '1; m_nextadr_i = '0;
    s_dat_i = '0; s_ack_i = 1'b1;
    #3;
    chk("rst_grant", 64'(grant_o), 64'd0);
    chk("rst_cyc",   64'(s_cyc_o), 64'd0);
    chk("rst_stb",   64'(s_stb_o), 64'd0);
    chk("rst_we",    64'(s_we_o),  64'd0);
    chk("rst_nav",   64'(s_nextadr_valid_o), 64'd0);
    chk("rst_ack",   64'(m_ack_o), 64'd0);
    @(posedge sys_clk); #1;
    chk("rst_hold_grant", 64'(grant_o), 64'd0);
    chk("rst_hold_cyc",   64'(s_cyc_o), 64'd0);

    // Single master 1 write, acked in its third owned cycle.
    do_reset();
    start_txn(1, 1, 1'b1, 32'h100);
    #1;
    chk("a_pre_cyc", 64'(s_cyc_o), 64'd0);
    step();
    chk("a_lat_cyc", 64'(s_cyc_o), 64'd1);
    chk("a_adr",     64'(s_adr_o), 64'h100);
    chk("a_sel",     64'(s_sel_o), 64'hFF);
    chk("a_grant",   64'(grant_o), 64'b010);
    step();
    step();
    s_ack_i = 1'b1;
    #1;
    chk("a_ack", 64'(m_ack_o), 64'b010);
    step();
    advance();
    s_ack_i = 1'b0;
    run(3);
    chk("a_ack_cnt1", 64'(ack_cnt[1]), 64'd1);

    // Masters 0 and 2 together from reset.
    do_reset();
    start_txn(0, 1, 1'b0, 32'h200);
    start_txn(2, 1, 1'b1, 32'h300);
    drive_slave();
    run(10);
    chk("b_ngrants", 64'(grant_log.size()), 64'd2);
    chk("b_first",   64'(log_at(0)), 64'd0);
    chk("b_second",  64'(log_at(1)), 64'd2);
    chk("b_gap",     64'(gap_at(1)), 64'd1);
    chk("b_ack0",    64'(ack_cnt[0]), 64'd1);
    chk("b_ack2",    64'(ack_cnt[2]), 64'd1);

    // Master 1 four-beat burst while master 0 waits.
    do_reset();
    start_txn(1, 4, 1'b1, 32'h400);
    drive_slave();
    step();
    start_txn(0, 1, 1'b0, 32'h500);
    drive_slave();
    run(15);
    chk("c_ngrants", 64'(grant_log.size()), 64'd2);
    chk("c_first",   64'(log_at(0)), 64'd1);
    chk("c_second",  64'(log_at(1)), 64'd0);
    chk("c_gap",     64'(gap_at(1)), 64'd1);
    chk("c_ack1",    64'(ack_cnt[1]), 64'd4);
    chk("c_ack0",    64'(ack_cnt[0]), 64'd1);

    // All three requesting continuously: rotation from reset.
    do_reset();
    for (int k = 0; k < NM; k++) auto_rs[k] = 1'b1;
    for (int k = 0; k < NM; k++) start_txn(k, 1, 1'b0, 32'h1000 + 32'(k) * 32'h100);
    drive_slave();
    for (int c = 0; c < 60 && grant_log.size() < 6; c++) begin
      step();
      advance();
      drive_slave();
    end
    chk("d_ngrants", 64'(grant_log.size() >= 6), 64'd1);
    for (int i = 0; i < 6; i++) chk($sformatf("d_order%0d", i), 64'(log_at(i)), 64'(i % NM));
    for (int k = 0; k < NM; k++) auto_rs[k] = 1'b0;

    // Reset pulse in the middle of a master 2 burst.
    do_reset();
    start_txn(2, 4, 1'b0, 32'h600);
    drive_slave();
    step();
    drive_slave();
    step();
    advance();
    drive_slave();
    #2;
    sys_rst = 1'b1;
    #1;
    chk("e_cyc",   64'(s_cyc_o), 64'd0);
    chk("e_stb",   64'(s_stb_o), 64'd0);
    chk("e_grant", 64'(grant_o), 64'd0);
    chk("e_ack",   64'(m_ack_o), 64'd0);
    mdl_owner = -1;
    mdl_rr    = 0;
    drop(2);
    start_txn(1, 1, 1'b0, 32'h700);
    drive_slave();
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    run(6);
    chk("e_ngrants", 64'(grant_log.size()), 64'd2);
    chk("e_before",  64'(log_at(0)), 64'd2);
    chk("e_after",   64'(log_at(1)), 64'd1);

    // Stray slave ack while idle.
    do_reset();
    s_ack_i = 1'b1;
    #1;
    chk("f_ack", 64'(m_ack_o), 64'd0);
    repeat (3) step();
    chk("f_grant", 64'(grant_o), 64'd0);
    s_ack_i = 1'b0;
    start_txn(0, 1, 1'b1, 32'h800);
    start_txn(1, 1, 1'b1, 32'h900);
    drive_slave();
    run(4);
    chk("f_first", 64'(log_at(0)), 64'd0);

    // Randomized traffic.
    do_reset();
    rnd_mode = 1'b1;
    drive_slave();
    run(3000);
    chk("g_activity", 64'(grant_log.size() > 50), 64'd1);
    begin
      int viol;
      viol = 0;
      for (int i = 1; i < gap_log.size(); i++) if (gap_log[i] < 1) viol++;
      chk("g_turnaround", 64'(viol), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
